// File: rtl/mul_norm_rnd.sv
// mul_norm_rnd: back end of a floating-point multiplier. Stage A normalises
// the raw mantissa product; stage B rounds to nearest-even, handles
// overflow, underflow and special operands, and packs {sign, exponent, fraction}.
// A single global stall (en) freezes both stages when the output is blocked.
module mul_norm_rnd #(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [SIGN_W-1:0]               in_sign,
    input  logic [EXPO_W+1:0]               in_expo,
    input  logic [2*MANT_W+1:0]             in_mant,
    input  logic [$clog2(MANT_W+1)-1:0]     in_zero_nums,
    input  logic                            in_is_nan,
    input  logic                            in_is_inf,
    input  logic                            in_is_zero,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [SIGN_W+EXPO_W+MANT_W-1:0] out_res,
    output logic                            out_of,
    output logic                            out_uf,
    output logic                            out_nx
);
    localparam int ZN_W  = $clog2(MANT_W+1);
    localparam int PW    = 2*MANT_W+2;
    localparam int EW    = EXPO_W+2;
    localparam int RES_W = SIGN_W+EXPO_W+MANT_W;
    localparam logic signed [EW-1:0] E_ONE    = EW'(1);
    localparam logic signed [EW:0]   E_MAX    = (EW+1)'((1 << EXPO_W) - 1);
    localparam logic [EXPO_W-1:0]    EXP_ONES = '1;

    // Global stall: the whole pipe moves only when the output slot can drain.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage A state
    logic                     a_valid;
    logic [SIGN_W-1:0]        a_sign;
    logic signed [EW-1:0]     a_e;
    logic [MANT_W-1:0]        a_frac;
    logic                     a_guard;
    logic                     a_sticky;
    logic                     a_nan;
    logic                     a_inf;
    logic                     a_zero;

    // Stage A combinational: normalising shift and field extraction.
    logic [PW-1:0]            sh;
    logic signed [EW-1:0]     e_base;
    logic signed [EW-1:0]     na_e;
    logic [MANT_W-1:0]        na_frac;
    logic                     na_guard;
    logic                     na_sticky;

    // Normalise: pick the fraction window depending on whether the product overflowed into bit 2*MANT_W+1.
    always_comb begin
        // NOTE: every variable is given a default first so no path can leave it unassigned and infer a latch.
        sh        = in_mant << in_zero_nums;
        e_base    = signed'(in_expo) - signed'({{(EW-ZN_W){1'b0}}, in_zero_nums});
        na_frac   = sh[2*MANT_W-1:MANT_W];
        na_guard  = sh[MANT_W-1];
        na_sticky = |sh[MANT_W-2:0];
        na_e      = e_base;
        if (sh[PW-1]) begin
            na_frac   = sh[2*MANT_W:MANT_W+1];
            na_guard  = sh[MANT_W];
            na_sticky = |sh[MANT_W-1:0];
            na_e      = e_base + E_ONE;
        end
    end

    // Stage B combinational: round, classify, pack.
    logic                     inc;
    logic [MANT_W:0]          frac_rnd;
    logic signed [EW:0]       e_rnd;
    logic                     under;
    logic                     over;
    logic [RES_W-1:0]         nb_res;
    logic                     nb_of;
    logic                     nb_uf;
    logic                     nb_nx;

    // Round to nearest even, then apply special > underflow > overflow > normal priority.
    always_comb begin
        inc      = a_guard & (a_sticky | a_frac[0]);
        frac_rnd = {1'b0, a_frac} + {{MANT_W{1'b0}}, inc};
        // A carry out of the fraction leaves its low bits at zero and bumps the exponent.
        e_rnd    = signed'({a_e[EW-1], a_e}) + signed'({{EW{1'b0}}, frac_rnd[MANT_W]});
        // Underflow is judged on the exponent before rounding.
        under    = a_e[EW-1] || (a_e == '0);
        over     = e_rnd >= E_MAX;
        nb_res   = {a_sign, e_rnd[EXPO_W-1:0], frac_rnd[MANT_W-1:0]};
        nb_of    = 1'b0;
        nb_uf    = 1'b0;
        nb_nx    = a_guard | a_sticky;
        if (a_nan) begin
            nb_res = {{SIGN_W{1'b0}}, EXP_ONES, 1'b1, {(MANT_W-1){1'b0}}};
            nb_nx  = 1'b0;
        end else if (a_inf) begin
            nb_res = {a_sign, EXP_ONES, {MANT_W{1'b0}}};
            nb_nx  = 1'b0;
        end else if (a_zero) begin
            nb_res = {a_sign, {(EXPO_W+MANT_W){1'b0}}};
            nb_nx  = 1'b0;
        end else if (under) begin
            nb_res = {a_sign, {(EXPO_W+MANT_W){1'b0}}};
            nb_uf  = 1'b1;
            nb_nx  = 1'b1;
        end else if (over) begin
            nb_res = {a_sign, EXP_ONES, {MANT_W{1'b0}}};
            nb_of  = 1'b1;
            nb_nx  = 1'b1;
        end
    end

    // Stage A payload: captured with every accepted beat.
    always_ff @(posedge clk) begin
        // NOTE: state is written with <= so every register samples values from before the edge.
        // NOTE: payload registers carry no reset; only the valid bits need a known value.
        if (en && in_valid) begin
            a_sign   <= in_sign;
            a_e      <= na_e;
            a_frac   <= na_frac;
            a_guard  <= na_guard;
            a_sticky <= na_sticky;
            a_nan    <= in_is_nan;
            a_inf    <= in_is_inf;
            a_zero   <= in_is_zero;
        end
    end

    // Valid bits and output register; reset discards in-flight beats and wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid   <= 1'b0;
            out_valid <= 1'b0;
            out_res   <= '0;
            out_of    <= 1'b0;
            out_uf    <= 1'b0;
            out_nx    <= 1'b0;
        end else if (en) begin
            a_valid   <= in_valid;
            out_valid <= a_valid;
            if (a_valid) begin
                out_res <= nb_res;
                out_of  <= nb_of;
                out_uf  <= nb_uf;
                out_nx  <= nb_nx;
            end
        end
    end

endmodule

// File: tb/tb_mul_norm_rnd.sv
// Self-checking bench for mul_norm_rnd (FP32 defaults): directed vectors,
// backpressure, mid-operation reset and a randomized stream scored against
// an arithmetic reference model.
module tb_mul_norm_rnd;
    typedef struct packed {
        logic [31:0] res;
        logic        of_f;
        logic        uf_f;
        logic        nx_f;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [0:0]  in_sign;
    logic [9:0]  in_expo;
    logic [47:0] in_mant;
    logic [4:0]  in_zero_nums;
    logic        in_is_nan;
    logic        in_is_inf;
    logic        in_is_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res;
    logic        out_of;
    logic        out_uf;
    logic        out_nx;

    always #5 clk = ~clk;

    mul_norm_rnd dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_expo      (in_expo),
        .in_mant      (in_mant),
        .in_zero_nums (in_zero_nums),
        .in_is_nan    (in_is_nan),
        .in_is_inf    (in_is_inf),
        .in_is_zero   (in_is_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_res      (out_res),
        .out_of       (out_of),
        .out_uf       (out_uf),
        .out_nx       (out_nx)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_out    = 0;
    exp_t sb[$];
    bit   held     = 1'b0;
    exp_t held_val;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t cur();
        return {out_res, out_of, out_uf, out_nx};
    endfunction

    // Reference: keep the top 24 bits of the product, compare the dropped
    // remainder against one half ulp, and classify the resulting exponent.
    function automatic exp_t ref_model(input logic s, input logic signed [9:0] expo,
                                       input logic [47:0] mant, input logic [4:0] zn,
                                       input logic nan, input logic inf, input logic zero);
        longint unsigned sh, q, rem, half, frac;
        int  k, e;
        bit  up;
        if (nan)  return {32'h7FC00000, 3'b000};
        if (inf)  return {s, 8'hFF, 23'h0, 3'b000};
        if (zero) return {s, 31'h0, 3'b000};
        sh = (64'(mant) << zn) & ((64'h1 << 48) - 64'h1);
        e  = int'(expo) - int'(zn);
        if ((sh >> 47) != 0) begin
            k = 24;
            e = e + 1;
        end else begin
            k = 23;
        end
        q    = sh >> k;
        rem  = sh & ((64'h1 << k) - 64'h1);
        half = 64'h1 << (k - 1);
        frac = q % (64'h1 << 23);
        up   = (rem > half) || (rem == half && (q % 2) == 1);
        if (e <= 0) return {s, 31'h0, 3'b011};
        if (up) begin
            frac = frac + 1;
            if (frac == (64'h1 << 23)) begin
                frac = 0;
                e    = e + 1;
            end
        end
        if (e >= 255) return {s, 8'hFF, 23'h0, 3'b101};
        return {s, 8'(e), 23'(frac), 2'b00, rem != 0};
    endfunction

    // One clock: observe #1 after the falling edge, score handshakes, advance to the next falling edge.
    task automatic tick(output bit accepted);
        exp_t e;
        #1;
        if (held) begin
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_data", 64'(cur()), 64'(held_val));
        end
        accepted = in_valid && in_ready;
        if (accepted)
            sb.push_back(ref_model(in_sign[0], in_expo, in_mant, in_zero_nums,
                                   in_is_nan, in_is_inf, in_is_zero));
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", 64'(out_valid), 64'(0));
            end else begin
                e = sb.pop_front();
                n_out++;
                check("result", 64'(cur()), 64'(e));
            end
        end
        held     = out_valid && !out_ready;
        held_val = cur();
        @(negedge clk);
    endtask

    task automatic gen_beat();
        logic [63:0] r64;
        logic [47:0] m;
        int          sft;
        int unsigned sp;
        r64          = {$urandom, $urandom};
        m            = r64[47:0];
        in_zero_nums = '0;
        case ($urandom_range(0, 3))
            0: m[47] = 1'b1;
            1: m[47:46] = 2'b01;
            2: begin
                sft          = int'($urandom_range(1, 8));
                m[47:46]     = 2'b01;
                m            = m >> sft;
                in_zero_nums = 5'(sft);
            end
            default: begin
                m[47:46] = 2'b01;
                m[22:0]  = 23'h400000;
            end
        endcase
        in_mant    = m;
        in_sign    = 1'($urandom_range(0, 1));
        in_expo    = 10'($urandom_range(0, 300) - 20);
        sp         = $urandom_range(0, 15);
        in_is_nan  = (sp == 0) || (sp == 3);
        in_is_inf  = (sp == 1) || (sp == 3);
        in_is_zero = (sp == 2) || (sp == 3);
    endtask

    task automatic drain();
        bit acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick(acc);
        tick(acc);
        check("drain_empty", 64'(sb.size()), 64'(0));
    endtask

    task automatic directed(input string tag, input logic s, input int expo, input logic [47:0] m,
                            input logic [31:0] r, input logic f_of, input logic f_uf, input logic f_nx);
        bit acc;
        out_ready    = 1'b1;
        in_valid     = 1'b1;
        in_sign      = s;
        in_expo      = 10'(expo);
        in_mant      = m;
        in_zero_nums = '0;
        in_is_nan    = 1'b0;
        in_is_inf    = 1'b0;
        in_is_zero   = 1'b0;
        tick(acc);
        check({tag, "_accept"}, 64'(acc), 64'(1));
        in_valid = 1'b0;
        check({tag, "_lat1"}, 64'(out_valid), 64'(0));
        tick(acc);
        check({tag, "_lat2"}, 64'(out_valid), 64'(1));
        check(tag, 64'(cur()), 64'({r, f_of, f_uf, f_nx}));
        tick(acc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit acc;
        int n0;
        int sent;
        bit pending;
        int guard_cnt;

        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        in_sign      = '0;
        in_expo      = '0;
        in_mant      = '0;
        in_zero_nums = '0;
        in_is_nan    = 1'b0;
        in_is_inf    = 1'b0;
        in_is_zero   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_outputs", 64'(cur()), 64'(0));
        rst = 1'b0;
        #1;
        check("reset_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);

        // Directed vectors
        directed("mul",  1'b0, 127, 48'h900000000000, 32'h40100000, 1'b0, 1'b0, 1'b0);
        directed("tie",  1'b0, 127, 48'h400000C00000, 32'h3F800002, 1'b0, 1'b0, 1'b1);
        directed("ovf",  1'b0, 254, 48'h900000000000, 32'h7F800000, 1'b1, 1'b0, 1'b1);
        directed("udf",  1'b1, 0,   48'h400000000000, 32'h80000000, 1'b0, 1'b1, 1'b1);
        directed("boundary_e1", 1'b0, 1, 48'h400000000000, 32'h00800000, 1'b0, 1'b0, 1'b0);

        // Backpressure: three beats with the output blocked
        drain();
        out_ready = 1'b0;
        n0        = n_out;
        for (int i = 0; i < 2; i++) begin
            gen_beat();
            in_valid = 1'b1;
            tick(acc);
            check("bp_accept", 64'(acc), 64'(1));
        end
        gen_beat();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(acc);
            check("bp_in_ready", 64'(acc), 64'(0));
            check("bp_out_valid", 64'(out_valid), 64'(1));
        end
        out_ready = 1'b1;
        acc       = 1'b0;
        guard_cnt = 0;
        while (!acc && guard_cnt < 10) begin
            tick(acc);
            guard_cnt++;
        end
        check("bp_third_accept", 64'(acc), 64'(1));
        drain();
        check("bp_count", 64'(n_out - n0), 64'(3));

        // Reset with both stages full and a handshake offered on the same edge
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            gen_beat();
            in_valid = 1'b1;
            tick(acc);
        end
        gen_beat();
        in_valid = 1'b1;
        tick(acc);
        check("mid_full", 64'(out_valid), 64'(1));
        rst       = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        held     = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_in_ready", 64'(in_ready), 64'(1));
        check("mid_rst_outputs", 64'(cur()), 64'(0));
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            tick(acc);
            check("mid_rst_no_stale", 64'(out_valid), 64'(0));
        end

        // Randomized stream with random backpressure
        sent    = 0;
        pending = 1'b0;
        for (int cyc = 0; cyc < 3000 && sent < 300; cyc++) begin
            if (!pending && $urandom_range(0, 4) != 0) begin
                gen_beat();
                pending = 1'b1;
            end
            in_valid  = pending;
            out_ready = ($urandom_range(0, 9) < 32'd7);
            tick(acc);
            if (acc) begin
                sent++;
                pending = 1'b0;
            end
        end
        check("rand_sent", 64'(sent), 64'(300));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
